// File: rtl/dma_s_axis_rx_buf_if.sv
// Stream-side signal bundle for the DMA receive buffer.
// A beat transfers on a rising clock edge where TVALID and TREADY are both high;
// the master holds TDATA/TSTRB/TLAST stable while TVALID is high and TREADY is low.
interface dma_s_axis_rx_buf_if #(
    parameter int DW = 64
);
    logic            TVALID;
    logic [DW-1:0]   TDATA;
    logic [DW/8-1:0] TSTRB;
    logic            TLAST;
    logic            TREADY;

    modport master (output TVALID, TDATA, TSTRB, TLAST, input TREADY);
    modport slave  (input TVALID, TDATA, TSTRB, TLAST, output TREADY);
endinterface

// File: rtl/dma_s_axis_rx_buf.sv
// AXI-Stream receive buffer: arms on a start edge, accepts one framed packet into a
// first-word-fall-through FIFO and flags TLAST framing errors against the expected length.
module dma_s_axis_rx_buf #(
    parameter int WAIT_COUNT_BITS        = 5,
    parameter int MAX_BIT_NUM_DMA_SYMBOL = 14,
    parameter int FIFO_ADDR_BITS         = 9,
    parameter int C_S_AXIS_TDATA_WIDTH   = 64
) (
    input  logic                              S_AXIS_ACLK,
    input  logic                              S_AXIS_ARESETN,
    input  logic                              endless_mode,
    input  logic [WAIT_COUNT_BITS-1:0]        START_COUNT_CFG,
    input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] S_AXIS_NUM_DMA_SYMBOL,
    input  logic                              start_1trans,
    dma_s_axis_rx_buf_if.slave                s_axis,
    input  logic                              RDEN_FROM_ACC,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   DATA_TO_ACC,
    output logic                              EMPTYN_TO_ACC,
    output logic [FIFO_ADDR_BITS:0]           data_count,
    output logic [MAX_BIT_NUM_DMA_SYMBOL:0]   rx_word_count,
    output logic                              rx_done,
    output logic                              err_tlast_early,
    output logic                              err_tlast_missing,
    output logic [1:0]                        dbg_state
);
    localparam int AW = FIFO_ADDR_BITS;
    localparam int WW = MAX_BIT_NUM_DMA_SYMBOL + 1;
    localparam logic [AW:0]              PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [WW-1:0]            WC_ONE   = {{(WW-1){1'b0}}, 1'b1};
    localparam logic [WAIT_COUNT_BITS-1:0] WAIT_ONE = {{(WAIT_COUNT_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RECV = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic                       start_ff_q, start_ff_d;
    logic [WAIT_COUNT_BITS-1:0] wait_cnt_q, wait_cnt_d;
    logic [WW-1:0]              rx_word_count_q, rx_word_count_d;
    logic                       rx_done_q, rx_done_d;
    logic                       err_tlast_early_q, err_tlast_early_d;
    logic                       err_tlast_missing_q, err_tlast_missing_d;
    logic [AW:0]                wr_ptr_q, wr_ptr_d;
    logic [AW:0]                rd_ptr_q, rd_ptr_d;
    logic [C_S_AXIS_TDATA_WIDTH-1:0] mem_q [2**AW];

    logic          start_pulse;
    logic          fifo_full;
    logic          fifo_empty;
    logic          tready;
    logic          push;
    logic          pop;
    logic [WW-1:0] n_last;
    logic          unused_tstrb;

    assign start_pulse = start_1trans & ~start_ff_q;
    assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
    assign fifo_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign tready      = (state_q == ST_RECV) && !fifo_full;
    assign push        = s_axis.TVALID & tready;
    assign pop         = RDEN_FROM_ACC & ~fifo_empty;
    assign n_last      = {1'b0, S_AXIS_NUM_DMA_SYMBOL};
    assign unused_tstrb = ^s_axis.TSTRB;

    always_comb begin
        start_ff_d          = start_1trans;
        state_d             = state_q;
        wait_cnt_d          = wait_cnt_q;
        rx_word_count_d     = rx_word_count_q;
        err_tlast_early_d   = err_tlast_early_q;
        err_tlast_missing_d = err_tlast_missing_q;
        rx_done_d           = 1'b0;
        wr_ptr_d            = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d            = rd_ptr_q + {{AW{1'b0}}, pop};
        case (state_q)
            ST_ARM: begin
                if (wait_cnt_q == START_COUNT_CFG) begin
                    state_d    = ST_RECV;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_ONE;
                end
            end
            ST_RECV: begin
                if (push) begin
                    rx_word_count_d = rx_word_count_q + WC_ONE;
                    // Checks use the index before the increment; an index past N-1
                    // (left over from endless streaming) ends on the very next beat.
                    if (!endless_mode) begin
                        if (rx_word_count_q < n_last) begin
                            if (s_axis.TLAST) begin
                                err_tlast_early_d = 1'b1;
                                state_d           = ST_IDLE;
                                rx_done_d         = 1'b1;
                            end
                        end else begin
                            state_d   = ST_IDLE;
                            rx_done_d = 1'b1;
                            if (!s_axis.TLAST) err_tlast_missing_d = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
        // A new arm request always wins; FIFO contents survive the restart.
        if (start_pulse) begin
            state_d             = ST_ARM;
            wait_cnt_d          = '0;
            rx_word_count_d     = '0;
            err_tlast_early_d   = 1'b0;
            err_tlast_missing_d = 1'b0;
            rx_done_d           = 1'b0;
        end
    end

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state_q             <= ST_IDLE;
            start_ff_q          <= 1'b0;
            wait_cnt_q          <= '0;
            rx_word_count_q     <= '0;
            rx_done_q           <= 1'b0;
            err_tlast_early_q   <= 1'b0;
            err_tlast_missing_q <= 1'b0;
            wr_ptr_q            <= '0;
            rd_ptr_q            <= '0;
        end else begin
            state_q             <= state_d;
            start_ff_q          <= start_ff_d;
            wait_cnt_q          <= wait_cnt_d;
            rx_word_count_q     <= rx_word_count_d;
            rx_done_q           <= rx_done_d;
            err_tlast_early_q   <= err_tlast_early_d;
            err_tlast_missing_q <= err_tlast_missing_d;
            wr_ptr_q            <= wr_ptr_d;
            rd_ptr_q            <= rd_ptr_d;
        end
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= s_axis.TDATA;
    end

    // Head is read straight from storage; forced to zero while empty so stale words never show.
    assign DATA_TO_ACC       = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign EMPTYN_TO_ACC     = ~fifo_empty;
    assign data_count        = wr_ptr_q - rd_ptr_q;
    assign s_axis.TREADY     = tready;
    assign rx_word_count     = rx_word_count_q;
    assign rx_done           = rx_done_q;
    assign err_tlast_early   = err_tlast_early_q;
    assign err_tlast_missing = err_tlast_missing_q;
    assign dbg_state         = state_q;
endmodule

// File: tb/tb_dma_s_axis_rx_buf.sv
// Bench for dma_s_axis_rx_buf: random packet data, a packet-level framing model and an
// in-order scoreboard of FIFO output words; FIFO depth is reduced to 16 to reach full quickly.
`timescale 1ns/1ps
module tb_dma_s_axis_rx_buf;
    localparam int WB = 5;
    localparam int MB = 14;
    localparam int AW = 4;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          endless_mode = 1'b0;
    logic [WB-1:0] start_cfg = '0;
    logic [MB-1:0] num_sym = '0;
    logic          start_1trans = 1'b0;
    logic          rden = 1'b0;
    logic [DW-1:0] data_to_acc;
    logic          emptyn;
    logic [AW:0]   data_count;
    logic [MB:0]   rx_word_count;
    logic          rx_done;
    logic          err_early;
    logic          err_missing;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [DW-1:0] sent_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];

    dma_s_axis_rx_buf_if #(.DW(DW)) axis ();

    dma_s_axis_rx_buf #(
        .WAIT_COUNT_BITS(WB), .MAX_BIT_NUM_DMA_SYMBOL(MB),
        .FIFO_ADDR_BITS(AW), .C_S_AXIS_TDATA_WIDTH(DW)
    ) dut (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n), .endless_mode(endless_mode),
        .START_COUNT_CFG(start_cfg), .S_AXIS_NUM_DMA_SYMBOL(num_sym), .start_1trans(start_1trans),
        .s_axis(axis.slave), .RDEN_FROM_ACC(rden), .DATA_TO_ACC(data_to_acc),
        .EMPTYN_TO_ACC(emptyn), .data_count(data_count), .rx_word_count(rx_word_count),
        .rx_done(rx_done), .err_tlast_early(err_early), .err_tlast_missing(err_missing),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(negedge clk) if (rst_n && rx_done) done_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic bit model_early(int n_last, int last_at, int offered);
        return (last_at >= 0) && (last_at < n_last) && (offered > last_at);
    endfunction

    function automatic int model_accept(int n_last, int last_at, int offered);
        if (model_early(n_last, last_at, offered)) return last_at + 1;
        return (offered < n_last + 1) ? offered : n_last + 1;
    endfunction

    function automatic bit model_missing(int n_last, int last_at, int offered);
        return !model_early(n_last, last_at, offered) && (offered > n_last) && (last_at != n_last);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic fill_sent(input int n);
        sent_q.delete();
        for (int i = 0; i < n; i++) sent_q.push_back({$urandom, $urandom});
    endtask

    task automatic build_exp(input int first, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(sent_q[first + i]);
    endtask

    // Pulses start_1trans and counts edges until TREADY is seen high.
    task automatic arm(input int cfg, output int k);
        start_cfg = WB'(cfg);
        start_1trans = 1'b1;
        k = 0;
        for (int c = 0; c < 64; c++) begin
            @(posedge clk); #1;
            k++;
            start_1trans = 1'b0;
            if (axis.TREADY) break;
        end
    endtask

    // Offers beats in order; stops at the first beat not taken within budget cycles.
    task automatic offer(input int first, input int n, input int last_at, input int budget, output int acc);
        bit took;
        acc = 0;
        for (int i = 0; i < n; i++) begin
            took = 1'b0;
            axis.TVALID = 1'b1;
            axis.TDATA  = sent_q[first + i];
            axis.TLAST  = (i == last_at);
            for (int w = 0; w < budget && !took; w++) begin
                @(negedge clk);
                took = axis.TREADY;
                @(posedge clk); #1;
            end
            if (!took) break;
            acc++;
        end
        axis.TVALID = 1'b0;
        axis.TLAST  = 1'b0;
    endtask

    task automatic pop_loop(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (emptyn) begin
                got_q.push_back(data_to_acc);
                rden = 1'b1;
            end else begin
                rden = 1'b0;
            end
        end
        @(posedge clk); #1;
        rden = 1'b0;
    endtask

    function automatic int score_diff();
        int bad = 0;
        if (got_q.size() != exp_q.size()) return 1000 + got_q.size();
        foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) bad++;
        return bad;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        axis.TVALID = 1'b0; axis.TDATA = '0; axis.TSTRB = '1; axis.TLAST = 1'b0;
        repeat (3) @(posedge clk); #1;
        checks++; if (axis.TREADY !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b expected 0", axis.TREADY); end
        checks++; if (emptyn !== 1'b0) begin errors++; $display("FAIL reset_emptyn: got %b expected 0", emptyn); end
        checks++; if (data_count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", data_count); end
        checks++; if (rx_word_count !== '0) begin errors++; $display("FAIL reset_wc: got %0d expected 0", rx_word_count); end
        checks++; if ({rx_done, err_early, err_missing} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {rx_done, err_early, err_missing}); end
        checks++; if (data_to_acc !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", data_to_acc); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    endtask

    task automatic test_basic();
        int k, acc, n_exp, bad;
        fill_sent(8); got_q.delete(); done_cnt = 0;
        num_sym = 7; endless_mode = 1'b0;
        arm(3, k);
        checks++; if (k !== 3 + 2) begin errors++; $display("FAIL basic_arm_latency: got %0d expected %0d", k, 5); end
        offer(0, 8, 7, 10, acc);
        n_exp = model_accept(7, 7, 8);
        checks++; if (acc !== n_exp) begin errors++; $display("FAIL basic_accepted: got %0d expected %0d", acc, n_exp); end
        repeat (2) @(posedge clk); #1;
        checks++; if (rx_word_count !== n_exp) begin errors++; $display("FAIL basic_wc: got %0d expected %0d", rx_word_count, n_exp); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL basic_done: got %0d expected 1", done_cnt); end
        checks++; if ({err_early, err_missing} !== 2'b00) begin errors++; $display("FAIL basic_err: got %b expected 00", {err_early, err_missing}); end
        checks++; if (data_count !== n_exp) begin errors++; $display("FAIL basic_count: got %0d expected %0d", data_count, n_exp); end
        checks++; if (axis.TREADY !== 1'b0) begin errors++; $display("FAIL basic_tready_after: got %b expected 0", axis.TREADY); end
        build_exp(0, n_exp); pop_loop(n_exp + 4);
        bad = score_diff();
        checks++; if (bad != 0) begin errors++; $display("FAIL basic_data: %0d words differ, expected 0", bad); end
    endtask

    task automatic test_framing(input string name, input int n_last, input int last_at, input int offered);
        int k, acc, n_exp, bad, cfg;
        bit e_exp, m_exp;
        fill_sent(offered); got_q.delete(); done_cnt = 0;
        num_sym = MB'(n_last); endless_mode = 1'b0;
        cfg = $urandom_range(0, 6);
        arm(cfg, k);
        checks++; if (k !== cfg + 2) begin errors++; $display("FAIL %s_arm_latency: got %0d expected %0d", name, k, cfg + 2); end
        offer(0, offered, last_at, 10, acc);
        n_exp = model_accept(n_last, last_at, offered);
        e_exp = model_early(n_last, last_at, offered);
        m_exp = model_missing(n_last, last_at, offered);
        checks++; if (acc !== n_exp) begin errors++; $display("FAIL %s_accepted: got %0d expected %0d", name, acc, n_exp); end
        checks++; if (rx_word_count !== n_exp) begin errors++; $display("FAIL %s_wc: got %0d expected %0d", name, rx_word_count, n_exp); end
        checks++; if (err_early !== e_exp) begin errors++; $display("FAIL %s_early: got %b expected %b", name, err_early, e_exp); end
        checks++; if (err_missing !== m_exp) begin errors++; $display("FAIL %s_missing: got %b expected %b", name, err_missing, m_exp); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL %s_done: got %0d expected 1", name, done_cnt); end
        checks++; if (axis.TREADY !== 1'b0) begin errors++; $display("FAIL %s_tready_after: got %b expected 0", name, axis.TREADY); end
        build_exp(0, n_exp); pop_loop(n_exp + 4);
        bad = score_diff();
        checks++; if (bad != 0) begin errors++; $display("FAIL %s_data: %0d words differ, expected 0", name, bad); end
    endtask

    task automatic test_restart();
        int k, acc, bad;
        fill_sent(2); got_q.delete();
        num_sym = 7; endless_mode = 1'b0;
        arm(2, k);
        offer(0, 2, -1, 10, acc);
        start_1trans = 1'b1;
        @(posedge clk); #1;
        start_1trans = 1'b0;
        checks++; if (rx_word_count !== '0) begin errors++; $display("FAIL restart_wc: got %0d expected 0", rx_word_count); end
        checks++; if (data_count !== 2) begin errors++; $display("FAIL restart_fifo_kept: got %0d expected 2", data_count); end
        checks++; if (axis.TREADY !== 1'b0) begin errors++; $display("FAIL restart_tready: got %b expected 0", axis.TREADY); end
        build_exp(0, 2); pop_loop(6);
        bad = score_diff();
        checks++; if (bad != 0) begin errors++; $display("FAIL restart_data: %0d words differ, expected 0", bad); end
    endtask

    task automatic test_fifo_full();
        int k, acc, bad;
        fill_sent(20); got_q.delete();
        num_sym = 100; endless_mode = 1'b0;
        arm(1, k);
        offer(0, 20, -1, 10, acc);
        checks++; if (acc !== 16) begin errors++; $display("FAIL full_accepted: got %0d expected 16", acc); end
        checks++; if (data_count !== 16) begin errors++; $display("FAIL full_count: got %0d expected 16", data_count); end
        checks++; if (axis.TREADY !== 1'b0) begin errors++; $display("FAIL full_tready: got %b expected 0", axis.TREADY); end
        @(negedge clk); got_q.push_back(data_to_acc); rden = 1'b1;
        @(posedge clk); #1; rden = 1'b0;
        offer(16, 4, -1, 10, acc);
        checks++; if (acc !== 1) begin errors++; $display("FAIL full_refill: got %0d expected 1", acc); end
        @(negedge clk); got_q.push_back(data_to_acc); rden = 1'b1;
        @(posedge clk); #1; rden = 1'b0;
        for (int i = 0; i < 3; i++) begin
            axis.TVALID = 1'b1; axis.TDATA = sent_q[17 + i]; rden = 1'b1;
            @(negedge clk);
            got_q.push_back(data_to_acc);
            checks++; if (axis.TREADY !== 1'b1) begin errors++; $display("FAIL full_pushpop_ready: got %b expected 1", axis.TREADY); end
            @(posedge clk); #1;
            checks++; if (data_count !== 15) begin errors++; $display("FAIL full_pushpop_count: got %0d expected 15", data_count); end
        end
        axis.TVALID = 1'b0; rden = 1'b0;
        pop_loop(30);
        build_exp(0, 20);
        bad = score_diff();
        checks++; if (bad != 0) begin errors++; $display("FAIL full_data: %0d words differ, expected 0", bad); end
        checks++; if (data_count !== 0) begin errors++; $display("FAIL full_drained: got %0d expected 0", data_count); end
    endtask

    task automatic test_endless();
        int k, acc, bad;
        fill_sent(101); got_q.delete(); done_cnt = 0;
        num_sym = 7; endless_mode = 1'b1;
        arm($urandom_range(0, 4), k);
        fork
            offer(0, 100, 10, 10, acc);
            pop_loop(150);
        join
        checks++; if (acc !== 100) begin errors++; $display("FAIL endless_accepted: got %0d expected 100", acc); end
        checks++; if (rx_word_count !== 100) begin errors++; $display("FAIL endless_wc: got %0d expected 100", rx_word_count); end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL endless_done: got %0d expected 0", done_cnt); end
        checks++; if ({err_early, err_missing} !== 2'b00) begin errors++; $display("FAIL endless_err: got %b expected 00", {err_early, err_missing}); end
        build_exp(0, 100);
        bad = score_diff();
        checks++; if (bad != 0) begin errors++; $display("FAIL endless_data: %0d words differ, expected 0", bad); end
        // Leaving endless mode past N-1: the next beat closes the packet.
        endless_mode = 1'b0;
        offer(100, 1, -1, 10, acc);
        repeat (2) @(posedge clk); #1;
        checks++; if (acc !== 1) begin errors++; $display("FAIL endless_exit_acc: got %0d expected 1", acc); end
        checks++; if (err_missing !== 1'b1) begin errors++; $display("FAIL endless_exit_missing: got %b expected 1", err_missing); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL endless_exit_done: got %0d expected 1", done_cnt); end
        checks++; if (rx_word_count !== 101) begin errors++; $display("FAIL endless_exit_wc: got %0d expected 101", rx_word_count); end
        got_q.delete(); pop_loop(5);
        build_exp(100, 1);
        bad = score_diff();
        checks++; if (bad != 0) begin errors++; $display("FAIL endless_exit_data: %0d words differ, expected 0", bad); end
    endtask

    task automatic test_async_reset();
        int k, acc;
        fill_sent(4);
        num_sym = 7; endless_mode = 1'b0;
        arm(2, k);
        offer(0, 3, -1, 10, acc);
        checks++; if (data_count !== 3) begin errors++; $display("FAIL async_pre_count: got %0d expected 3", data_count); end
        axis.TVALID = 1'b1; axis.TDATA = sent_q[3];
        #2 rst_n = 1'b0;
        #1;
        checks++; if (axis.TREADY !== 1'b0) begin errors++; $display("FAIL async_tready: got %b expected 0", axis.TREADY); end
        checks++; if (emptyn !== 1'b0) begin errors++; $display("FAIL async_emptyn: got %b expected 0", emptyn); end
        checks++; if (data_count !== '0) begin errors++; $display("FAIL async_count: got %0d expected 0", data_count); end
        checks++; if (rx_word_count !== '0) begin errors++; $display("FAIL async_wc: got %0d expected 0", rx_word_count); end
        checks++; if (data_to_acc !== '0) begin errors++; $display("FAIL async_data: got %h expected 0", data_to_acc); end
        axis.TVALID = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL async_state: got %0d expected 0", dbg_state); end
        checks++; if (emptyn !== 1'b0) begin errors++; $display("FAIL async_post_emptyn: got %b expected 0", emptyn); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_framing("early", 7, 3, 8);
        test_framing("missing", 3, -1, 5);
        test_restart();
        test_fifo_full();
        test_endless();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
